// File: rtl/bitmap_mover_if.sv
// bitmap_mover_if: command, register-file bitmap port and memory bus of the bitmap mover.
interface bitmap_mover_if #(
    parameter int WORD_W = 16,
    parameter int BM_W   = 1536,
    parameter int ADDR_W = 16
);
    logic              start, op, busy, done;
    logic [1:0]        bm_idx, rbm_addr, wbm_addr;
    logic [ADDR_W-1:0] base_addr, mem_addr;
    logic [BM_W-1:0]   rbm_data, wbm_data;
    logic              wbm, mem_req, mem_we, mem_ack;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  start, op, bm_idx, base_addr, rbm_data, mem_ack, mem_rdata,
        output busy, done, rbm_addr, wbm_addr, wbm_data, wbm, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output start, op, bm_idx, base_addr, rbm_data, mem_ack, mem_rdata,
        input  busy, done, rbm_addr, wbm_addr, wbm_data, wbm, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bitmap_mover.sv
// bitmap_mover: moves a bitmap register to/from word-wide memory, one word per beat.
// BITMAP_MOVER_CLEAR_EN adds clr_i: a start with clr_i=1 commits an all-zero bitmap without memory traffic.
module bitmap_mover #(
    parameter int WORD_W = 16,
    parameter int BM_W   = 1536,
    parameter int ADDR_W = 16,
    parameter int BEATS  = BM_W / WORD_W
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BITMAP_MOVER_CLEAR_EN
    input  logic clr_i,
`endif
    bitmap_mover_if.slave bus
);
    localparam int KW = $clog2(BEATS);
    typedef enum logic [1:0] {IDLE, XFER, COMMIT, DONE} state_t;
    state_t            state_q, state_d;
    logic              op_q, op_d, clr, xfer, commit;
    logic [1:0]        idx_q, idx_d, idx_in;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [KW-1:0]     k_q, k_d;
    logic [BM_W-1:0]   buf_q, buf_d;
`ifdef BITMAP_MOVER_CLEAR_EN
    assign clr = clr_i;
`else
    assign clr = 1'b0;
`endif
    // register 3 aliases register 0
    assign idx_in = (bus.bm_idx == 2'd3) ? 2'd0 : bus.bm_idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            idx_q   <= '0;
            base_q  <= '0;
            k_q     <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        base_d  = base_q;
        k_d     = k_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                op_d    = bus.op;
                idx_d   = idx_in;
                base_d  = bus.base_addr;
                k_d     = '0;
                buf_d   = clr ? '0 : bus.op ? bus.rbm_data : buf_q;
                state_d = clr ? COMMIT : XFER;
            end
            XFER: if (bus.mem_ack) begin
                if (!op_q) buf_d[int'(k_q)*WORD_W +: WORD_W] = bus.mem_rdata;
                k_d = k_q + 1'b1;
                if (k_q == KW'(BEATS - 1)) state_d = op_q ? DONE : COMMIT;
            end
            COMMIT: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    assign xfer          = (state_q == XFER);
    assign commit        = (state_q == COMMIT);
    assign bus.busy      = xfer || commit;
    assign bus.done      = (state_q == DONE);
    assign bus.rbm_addr  = (state_q == IDLE) ? idx_in : idx_q;
    assign bus.wbm       = commit;
    assign bus.wbm_addr  = commit ? idx_q : '0;
    assign bus.wbm_data  = commit ? buf_q : '0;
    assign bus.mem_req   = xfer;
    assign bus.mem_we    = xfer && op_q;
    assign bus.mem_addr  = xfer ? base_q + ADDR_W'(k_q) : '0;
    assign bus.mem_wdata = (xfer && op_q) ? buf_q[int'(k_q)*WORD_W +: WORD_W] : '0;
endmodule

// File: tb/tb_bitmap_mover.sv
// tb_bitmap_mover: directed store/load/wrap/reject/reset checks for bitmap_mover.
// Define BITMAP_MOVER_CLEAR_EN to also exercise the clear command.
module tb_bitmap_mover;
    logic clk = 1'b0, rst_n = 1'b0;
    int total = 0, bad = 0;
    logic [15:0]   mem [0:65535];
    logic [1535:0] regs [4];
    logic [1535:0] exp_bm, wbm_data_s;
    logic [1:0]    wbm_addr_s;
    logic [15:0]   last_addr;
    int beats, done_cnt, wbm_cnt, done_cyc, wbm_cyc, addr_bad, busy_bad, miss;
    bitmap_mover_if bus ();
`ifdef BITMAP_MOVER_CLEAR_EN
    logic clr = 1'b0;
    bitmap_mover dut (.clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(bus));
`else
    bitmap_mover dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
    always #5 clk = ~clk;
    assign bus.rbm_data  = regs[bus.rbm_addr];
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bm(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got word0 %0h word95 %0h want word0 %0h word95 %0h",
                   tag, obs[15:0], obs[1535:1520], exp[15:0], exp[1535:1520]);
        end
    endtask

    // one command from IDLE; acks when cycle%per==0; optional second start at restart_at
    task automatic run(input logic op_v, input logic [1:0] idx, input logic [15:0] base,
                       input int per, input int restart_at, input int exp_done);
        beats = 0; done_cnt = 0; wbm_cnt = 0; done_cyc = -1; wbm_cyc = -1;
        addr_bad = 0; busy_bad = 0; last_addr = 16'hxxxx;
        bus.op = op_v; bus.bm_idx = idx; bus.base_addr = base; bus.start = 1'b1; bus.mem_ack = 1'b0;
        for (int n = 1; n <= 400 && !(done_cyc > 0 && n > done_cyc + 4); n++) begin
            @(negedge clk);
            bus.start = (n == restart_at);
            if (n == restart_at) bus.base_addr = base + 16'h0040;
            bus.mem_ack = (n % per == 0);
            if (bus.busy !== (n < exp_done)) busy_bad++;
            if (bus.mem_req) begin
                if (bus.mem_addr !== base + 16'(beats) || bus.mem_we !== op_v) addr_bad++;
                if (bus.mem_ack) begin
                    if (op_v) mem[bus.mem_addr] = bus.mem_wdata;
                    last_addr = bus.mem_addr;
                    beats++;
                end
            end
            if (bus.wbm) begin
                wbm_cnt++; wbm_cyc = n; wbm_addr_s = bus.wbm_addr; wbm_data_s = bus.wbm_data;
                regs[bus.wbm_addr] = bus.wbm_data;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
        end
        bus.start = 1'b0; bus.mem_ack = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        for (int r = 0; r < 4; r++) regs[r] = {96{16'h1111 * 16'(r + 1)}};
        for (int k = 0; k < 96; k++) begin
            regs[1][k*16 +: 16] = 16'hA000 + 16'(k);
            mem[16'h2000 + 16'(k)] = ~16'(k);
            mem[16'hFFF0 + 16'(k)] = 16'h5000 + 16'(k);
            mem[16'h4000 + 16'(k)] = 16'h7700 + 16'(k);
        end
        bus.start = 1'b0; bus.op = 1'b0; bus.bm_idx = '0; bus.base_addr = '0; bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_wbm", 32'(bus.wbm), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_mem_we", 32'(bus.mem_we), 0);
        chk("idle_mem_addr", 32'(bus.mem_addr), 0);
        chk("idle_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("idle_wbm_addr", 32'(bus.wbm_addr), 0);
        chk_bm("idle_wbm_data", bus.wbm_data, '0);
        bus.bm_idx = 2'd3;
        #1 chk("idle_rbm_alias", 32'(bus.rbm_addr), 0);

        run(1'b1, 2'd1, 16'h0100, 1, -1, 97);
        chk("st_beats", beats, 96);
        chk("st_done_cyc", done_cyc, 97);
        chk("st_done_cnt", done_cnt, 1);
        chk("st_wbm_cnt", wbm_cnt, 0);
        chk("st_addr", addr_bad, 0);
        chk("st_busy", busy_bad, 0);
        miss = 0;
        for (int k = 0; k < 96; k++) if (mem[16'h0100 + 16'(k)] !== 16'hA000 + 16'(k)) miss++;
        chk("st_mem_data", miss, 0);
        chk("st_mem_after", 32'(mem[16'h0160]), 0);

        run(1'b0, 2'd2, 16'h2000, 3, -1, 290);
        for (int k = 0; k < 96; k++) exp_bm[k*16 +: 16] = ~16'(k);
        chk("ld_beats", beats, 96);
        chk("ld_addr_stable", addr_bad, 0);
        chk("ld_wbm_cnt", wbm_cnt, 1);
        chk("ld_wbm_cyc", wbm_cyc, 289);
        chk("ld_done_cyc", done_cyc, 290);
        chk("ld_wbm_addr", 32'(wbm_addr_s), 2);
        chk_bm("ld_wbm_data", wbm_data_s, exp_bm);
        chk("ld_busy", busy_bad, 0);

        run(1'b0, 2'd3, 16'hFFF0, 1, -1, 98);
        for (int k = 0; k < 96; k++) exp_bm[k*16 +: 16] = 16'h5000 + 16'(k);
        chk("wr_addr_seq", addr_bad, 0);
        chk("wr_last_addr", 32'(last_addr), 32'h004F);
        chk("wr_wbm_addr", 32'(wbm_addr_s), 0);
        chk("wr_wbm_cyc", wbm_cyc, 97);
        chk("wr_done_cyc", done_cyc, 98);
        chk_bm("wr_wbm_data", wbm_data_s, exp_bm);

        run(1'b1, 2'd1, 16'h3000, 1, 10, 97);
        chk("rj_beats", beats, 96);
        chk("rj_done_cnt", done_cnt, 1);
        chk("rj_addr", addr_bad, 0);
        chk("rj_mem_after", 32'(mem[16'h3060]), 0);

        bus.op = 1'b0; bus.bm_idx = 2'd2; bus.base_addr = 16'h4000; bus.start = 1'b1; bus.mem_ack = 1'b1;
        beats = 0;
        for (int n = 1; n <= 200 && beats < 50; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.mem_req) beats++;
        end
        @(negedge clk);
        rst_n = 1'b0; bus.mem_ack = 1'b0;
        #1;
        chk("rs_mem_req", 32'(bus.mem_req), 0);
        chk("rs_busy", 32'(bus.busy), 0);
        wbm_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            if (bus.wbm) wbm_cnt++;
            if (bus.done) done_cnt++;
        end
        chk("rs_no_wbm", wbm_cnt, 0);
        chk("rs_no_done", done_cnt, 0);
        run(1'b0, 2'd2, 16'h4000, 1, -1, 98);
        for (int k = 0; k < 96; k++) exp_bm[k*16 +: 16] = 16'h7700 + 16'(k);
        chk("rs_again_done", done_cyc, 98);
        chk("rs_again_wbm_cnt", wbm_cnt, 1);
        chk_bm("rs_again_data", wbm_data_s, exp_bm);

`ifdef BITMAP_MOVER_CLEAR_EN
        clr = 1'b1; bus.op = 1'b1; bus.bm_idx = 2'd0; bus.base_addr = 16'h0500; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; clr = 1'b0;
        chk("cl_wbm", 32'(bus.wbm), 1);
        chk("cl_wbm_addr", 32'(bus.wbm_addr), 0);
        chk_bm("cl_wbm_data", bus.wbm_data, '0);
        chk("cl_mem_req1", 32'(bus.mem_req), 0);
        @(negedge clk);
        chk("cl_done", 32'(bus.done), 1);
        chk("cl_mem_req2", 32'(bus.mem_req), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
